// File: rtl/intctrl.sv
// intctrl: edge-triggered interrupt collector that dispatches sources to ready PUs over
// intrqst/intrdy and exposes a single PI1 claim/EOI register. Define INTCTRL_IPI_EN for IPIs.
module intctrl #(
  parameter int unsigned ARCHBITSZ  = 32,
  parameter int unsigned PUCOUNT    = 2,
  parameter int unsigned SRCCOUNT   = 8,
  parameter int unsigned ACKTIMEOUT = 1024
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [SRCCOUNT-1:0]                      src_i,
  output logic [PUCOUNT-1:0]                       intrqst_o,
  input  logic [PUCOUNT-1:0]                       intrdy_i,
  input  logic [1:0]                               pi1_op_i,
  input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0] pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]                     pi1_data_i,
  output logic [ARCHBITSZ-1:0]                     pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0]                   pi1_sel_i,
  output logic                                     pi1_rdy_o
);

  localparam int unsigned SW = (SRCCOUNT > 1) ? $clog2(SRCCOUNT) : 1;
  localparam int unsigned PW = (PUCOUNT > 1) ? $clog2(PUCOUNT) : 1;
  localparam int unsigned CW = (ACKTIMEOUT > 1) ? $clog2(ACKTIMEOUT) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SENT = 1'b1
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [SRCCOUNT-1:0]    r_src_q;
  logic [SRCCOUNT-1:0]    r_pending, w_pending_nxt;
  logic [SRCCOUNT-1:0]    r_inservice, w_inservice_nxt;
  logic [PUCOUNT-1:0]     r_intrqst, w_intrqst_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [SW-1:0]          r_sel_src, w_sel_src_nxt;
  logic [PW-1:0]          r_sel_pu, w_sel_pu_nxt;
  logic [SW-1:0]          r_src_ptr, w_src_ptr_nxt;
  logic [PW-1:0]          r_pu_ptr, w_pu_ptr_nxt;
  logic [ARCHBITSZ-1:0]   r_data_o, w_data_nxt;

  logic [ARCHBITSZ-1:0]   r_fifo [PUCOUNT];
  logic [PW-1:0]          r_fifo_wr;
  logic [PW-1:0]          r_fifo_rd;
  logic [PW:0]            r_fifo_cnt;

  logic [SRCCOUNT-1:0]    w_edge;
  logic [SRCCOUNT-1:0]    w_elig;
  logic [SRCCOUNT-1:0]    w_take_src;
  logic [SRCCOUNT-1:0]    w_wr_clr;
  logic                   w_src_found;
  logic [SW-1:0]          w_src_idx;
  logic                   w_pu_found;
  logic [PW-1:0]          w_pu_idx;
  logic                   w_fifo_full;
  logic                   w_push;
  logic [ARCHBITSZ-1:0]   w_push_data;
  logic                   w_pop;
  logic                   w_rd;
  logic                   w_wr;
  logic                   w_unused_ok;

`ifdef INTCTRL_IPI_EN
  logic [PUCOUNT-1:0]     r_ipipending, w_ipipending_nxt;
  logic                   r_sel_ipi, w_sel_ipi_nxt;
  logic [PUCOUNT-1:0]     w_ipi_set;
  logic [PUCOUNT-1:0]     w_ipi_clr;
  logic [PUCOUNT-1:0]     w_ipi_cand;
  logic                   w_ipi_found;
  logic [PW-1:0]          w_ipi_pu;
`endif

  function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned off,
                                           input int unsigned modulus);
    int unsigned sum;
    sum = base + off;
    return (sum >= modulus) ? sum - modulus : sum;
  endfunction

  function automatic logic [SW-1:0] src_inc(input logic [SW-1:0] v);
    return (v == SW'(SRCCOUNT - 1)) ? '0 : v + SW'(1);
  endfunction

  function automatic logic [PW-1:0] pu_inc(input logic [PW-1:0] v);
    return (v == PW'(PUCOUNT - 1)) ? '0 : v + PW'(1);
  endfunction

  assign intrqst_o   = r_intrqst;
  assign pi1_data_o  = r_data_o;
  assign pi1_rdy_o   = 1'b1;
  assign w_unused_ok = ^{pi1_addr_i, pi1_sel_i};

  assign w_rd        = pi1_op_i[1];
  assign w_wr        = pi1_op_i[0];
  assign w_edge      = src_i & ~r_src_q;
  assign w_elig      = r_pending & ~r_inservice;
  assign w_fifo_full = (r_fifo_cnt == (PW+1)'(PUCOUNT));
  assign w_pop       = w_rd && (r_fifo_cnt != '0);

  // Round-robin pick of an eligible source and of a ready PU.
  always_comb begin
    w_src_found = 1'b0;
    w_src_idx   = '0;
    for (int unsigned i = 0; i < SRCCOUNT; i++) begin
      if (!w_src_found && w_elig[SW'(wrap_idx(32'(r_src_ptr), i, SRCCOUNT))]) begin
        w_src_found = 1'b1;
        w_src_idx   = SW'(wrap_idx(32'(r_src_ptr), i, SRCCOUNT));
      end
    end
    w_pu_found = 1'b0;
    w_pu_idx   = '0;
    for (int unsigned i = 0; i < PUCOUNT; i++) begin
      if (!w_pu_found && intrdy_i[PW'(wrap_idx(32'(r_pu_ptr), i, PUCOUNT))]) begin
        w_pu_found = 1'b1;
        w_pu_idx   = PW'(wrap_idx(32'(r_pu_ptr), i, PUCOUNT));
      end
    end
  end

`ifdef INTCTRL_IPI_EN
  // IPIs: MSB-tagged writes target a PU; ready PUs with an IPI pending win over sources.
  assign w_ipi_cand = intrdy_i & r_ipipending;

  always_comb begin
    w_ipi_found = 1'b0;
    w_ipi_pu    = '0;
    for (int unsigned i = 0; i < PUCOUNT; i++) begin
      if (!w_ipi_found && w_ipi_cand[PW'(wrap_idx(32'(r_pu_ptr), i, PUCOUNT))]) begin
        w_ipi_found = 1'b1;
        w_ipi_pu    = PW'(wrap_idx(32'(r_pu_ptr), i, PUCOUNT));
      end
    end
    w_ipi_set = '0;
    if (w_wr && pi1_data_i[ARCHBITSZ-1] && (32'(pi1_data_i[PW-1:0]) < PUCOUNT)) begin
      w_ipi_set[pi1_data_i[PW-1:0]] = 1'b1;
    end
    w_ipipending_nxt = (r_ipipending & ~w_ipi_clr) | w_ipi_set;
  end
`endif

  // Dispatch FSM: IDLE picks (source, PU); SENT waits for the take or the ack timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_intrqst_nxt = r_intrqst;
    w_cnt_nxt     = r_cnt;
    w_sel_src_nxt = r_sel_src;
    w_sel_pu_nxt  = r_sel_pu;
    w_src_ptr_nxt = r_src_ptr;
    w_pu_ptr_nxt  = r_pu_ptr;
    w_push        = 1'b0;
    w_push_data   = '0;
    w_take_src    = '0;
`ifdef INTCTRL_IPI_EN
    w_sel_ipi_nxt = r_sel_ipi;
    w_ipi_clr     = '0;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef INTCTRL_IPI_EN
        if (w_ipi_found && !w_fifo_full) begin
          w_state_nxt             = S_SENT;
          w_sel_pu_nxt            = w_ipi_pu;
          w_sel_ipi_nxt           = 1'b1;
          w_pu_ptr_nxt            = pu_inc(w_ipi_pu);
          w_cnt_nxt               = '0;
          w_intrqst_nxt           = '0;
          w_intrqst_nxt[w_ipi_pu] = 1'b1;
        end else
`endif
        if (w_src_found && w_pu_found && !w_fifo_full) begin
          w_state_nxt             = S_SENT;
          w_sel_src_nxt           = w_src_idx;
          w_sel_pu_nxt            = w_pu_idx;
          w_src_ptr_nxt           = src_inc(w_src_idx);
          w_pu_ptr_nxt            = pu_inc(w_pu_idx);
          w_cnt_nxt               = '0;
          w_intrqst_nxt           = '0;
          w_intrqst_nxt[w_pu_idx] = 1'b1;
`ifdef INTCTRL_IPI_EN
          w_sel_ipi_nxt           = 1'b0;
`endif
        end
      end
      S_SENT: begin
        if (!intrdy_i[r_sel_pu]) begin
          w_state_nxt   = S_IDLE;
          w_intrqst_nxt = '0;
          w_push        = 1'b1;
`ifdef INTCTRL_IPI_EN
          if (r_sel_ipi) begin
            w_push_data         = ~ARCHBITSZ'(1);
            w_ipi_clr[r_sel_pu] = 1'b1;
          end else
`endif
          begin
            w_push_data           = ARCHBITSZ'(r_sel_src);
            w_take_src[r_sel_src] = 1'b1;
          end
        end else if ((ACKTIMEOUT != 0) && (r_cnt == CW'(ACKTIMEOUT - 1))) begin
          w_state_nxt   = S_IDLE;
          w_intrqst_nxt = '0;
        end else if (ACKTIMEOUT != 0) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
    endcase
  end

  // EOI writes, edge capture and claim-register read data.
  always_comb begin
    w_wr_clr = '0;
    if (w_wr && (pi1_data_i < ARCHBITSZ'(SRCCOUNT))) begin
      w_wr_clr[SW'(pi1_data_i)] = 1'b1;
    end
    w_inservice_nxt = (r_inservice & ~w_wr_clr) | w_take_src;
    w_pending_nxt   = (r_pending & ~w_take_src) | (w_edge & ~w_inservice_nxt);
    w_data_nxt      = r_data_o;
    if (w_rd) begin
      w_data_nxt = (r_fifo_cnt != '0) ? r_fifo[r_fifo_rd] : '1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_src_q     <= '0;
      r_pending   <= '0;
      r_inservice <= '0;
      r_intrqst   <= '0;
      r_cnt       <= '0;
      r_sel_src   <= '0;
      r_sel_pu    <= '0;
      r_src_ptr   <= '0;
      r_pu_ptr    <= '0;
      r_data_o    <= '0;
      r_fifo_wr   <= '0;
      r_fifo_rd   <= '0;
      r_fifo_cnt  <= '0;
      for (int unsigned i = 0; i < PUCOUNT; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_src_q     <= src_i;
      r_pending   <= w_pending_nxt;
      r_inservice <= w_inservice_nxt;
      r_intrqst   <= w_intrqst_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sel_src   <= w_sel_src_nxt;
      r_sel_pu    <= w_sel_pu_nxt;
      r_src_ptr   <= w_src_ptr_nxt;
      r_pu_ptr    <= w_pu_ptr_nxt;
      r_data_o    <= w_data_nxt;
      if (w_push) begin
        r_fifo[r_fifo_wr] <= w_push_data;
        r_fifo_wr         <= pu_inc(r_fifo_wr);
      end
      if (w_pop) begin
        r_fifo_rd <= pu_inc(r_fifo_rd);
      end
      r_fifo_cnt <= r_fifo_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

`ifdef INTCTRL_IPI_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ipipending <= '0;
      r_sel_ipi    <= 1'b0;
    end else begin
      r_ipipending <= w_ipipending_nxt;
      r_sel_ipi    <= w_sel_ipi_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_intctrl.sv
// Self-checking bench for intctrl: directed scenarios plus randomized source bursts
// checked against a round-robin dispatch-order model.
module tb_intctrl;

  localparam int unsigned ARCHBITSZ  = 32;
  localparam int unsigned PUCOUNT    = 2;
  localparam int unsigned SRCCOUNT   = 8;
  localparam int unsigned ACKTIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src;
  logic [1:0]  intrqst;
  logic [1:0]  intrdy;
  logic [1:0]  rdy_man;
  logic [1:0]  rdy_auto = 2'b11;
  logic        auto_en;
  logic [1:0]  op;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  sel;
  logic        prdy;

  int n_vec = 0;
  int n_err = 0;

  assign intrdy = auto_en ? rdy_auto : rdy_man;

  intctrl #(
    .ARCHBITSZ (ARCHBITSZ),
    .PUCOUNT   (PUCOUNT),
    .SRCCOUNT  (SRCCOUNT),
    .ACKTIMEOUT(ACKTIMEOUT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .src_i     (src),
    .intrqst_o (intrqst),
    .intrdy_i  (intrdy),
    .pi1_op_i  (op),
    .pi1_addr_i(addr),
    .pi1_data_i(wdata),
    .pi1_data_o(rdata),
    .pi1_sel_i (sel),
    .pi1_rdy_o (prdy)
  );

  always #5 clk = ~clk;

  // Auto PU: takes any request on the negedge after it appears.
  always @(negedge clk) rdy_auto = ~intrqst;

  task automatic do_reset();
    rst = 1'b0; src = '0; op = 2'd0; addr = '0; wdata = '0; sel = '1;
    auto_en = 1'b0; rdy_man = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pi_rd(output logic [31:0] d);
    @(negedge clk); op = 2'd2;
    @(negedge clk); op = 2'd0;
    d = rdata;
  endtask

  task automatic pi_wr(input logic [31:0] d);
    @(negedge clk); op = 2'd1; wdata = d;
    @(negedge clk); op = 2'd0;
  endtask

  task automatic pulse_src(input logic [7:0] m);
    @(negedge clk); src = m;
    @(negedge clk); src = '0;
  endtask

  task automatic wait_rqst(input logic [1:0] want, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (intrqst === want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0; src = '0; op = 2'd0; addr = '0; wdata = '0; sel = '1;
    auto_en = 1'b0; rdy_man = 2'b11;
    repeat (2) @(negedge clk);
    n_vec++;
    if (intrqst !== 2'b00) begin n_err++; $display("FAIL reset_intrqst: got %b expected 00", intrqst); end
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 00000000", rdata); end
    n_vec++;
    if (prdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b expected 1", prdy); end
    rst = 1'b1;
    @(negedge clk);
    pi_rd(d);
    n_vec++;
    if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_rd_empty: got %h expected ffffffff", d); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    bit ok;
    do_reset();
    rdy_man = 2'b01;
    pulse_src(8'h08);
    wait_rqst(2'b01, 3, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL single_rqst: got %b expected 01", intrqst); end
    rdy_man = 2'b00;
    @(negedge clk);
    n_vec++;
    if (intrqst !== 2'b00) begin n_err++; $display("FAIL single_take: got %b expected 00", intrqst); end
    pi_rd(d);
    n_vec++;
    if (d !== 32'd3) begin n_err++; $display("FAIL single_claim: got %h expected 3", d); end
    pi_wr(32'd3);
    rdy_man = 2'b01;
    pulse_src(8'h08);
    wait_rqst(2'b01, 3, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL single_redispatch: got %b expected 01", intrqst); end
    rdy_man = 2'b00;
    @(negedge clk);
    pi_rd(d);
    n_vec++;
    if (d !== 32'd3) begin n_err++; $display("FAIL single_claim2: got %h expected 3", d); end
  endtask

  task automatic test_two_sources();
    logic [31:0] d;
    logic [1:0]  seq[$];
    logic [1:0]  prev;
    do_reset();
    auto_en = 1'b1;
    pulse_src(8'h22);
    prev = 2'b00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (intrqst !== 2'b00 && prev === 2'b00) seq.push_back(intrqst);
      prev = intrqst;
    end
    auto_en = 1'b0;
    n_vec++;
    if (seq.size() != 2) begin n_err++; $display("FAIL two_count: got %0d expected 2", seq.size()); end
    else begin
      n_vec++;
      if (seq[0] !== 2'b01) begin n_err++; $display("FAIL two_pu0: got %b expected 01", seq[0]); end
      n_vec++;
      if (seq[1] !== 2'b10) begin n_err++; $display("FAIL two_pu1: got %b expected 10", seq[1]); end
    end
    pi_rd(d);
    n_vec++;
    if (d !== 32'd1) begin n_err++; $display("FAIL two_rd1: got %h expected 1", d); end
    pi_rd(d);
    n_vec++;
    if (d !== 32'd5) begin n_err++; $display("FAIL two_rd5: got %h expected 5", d); end
    pi_rd(d);
    n_vec++;
    if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL two_rd_empty: got %h expected ffffffff", d); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    bit ok;
    int n;
    do_reset();
    rdy_man = 2'b01;
    pulse_src(8'h04);
    wait_rqst(2'b01, 3, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL to_rqst: got %b expected 01", intrqst); end
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (n == 5) rdy_man = 2'b11;
      if (intrqst === 2'b01) n++;
      else break;
    end
    n_vec++;
    if (n != int'(ACKTIMEOUT)) begin n_err++; $display("FAIL to_width: got %0d expected %0d", n, ACKTIMEOUT); end
    n_vec++;
    if (intrqst !== 2'b00) begin n_err++; $display("FAIL to_drop: got %b expected 00", intrqst); end
    wait_rqst(2'b10, 3, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL to_retry: got %b expected 10", intrqst); end
    rdy_man = 2'b01;
    @(negedge clk);
    pi_rd(d);
    n_vec++;
    if (d !== 32'd2) begin n_err++; $display("FAIL to_claim: got %h expected 2", d); end
  endtask

  task automatic test_merge();
    logic [31:0] d;
    bit ok;
    bit seen;
    do_reset();
    rdy_man = 2'b01;
    pulse_src(8'h10);
    wait_rqst(2'b01, 3, ok);
    rdy_man = 2'b00;
    @(negedge clk);
    rdy_man = 2'b01;
    pulse_src(8'h10);
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (intrqst !== 2'b00) seen = 1'b1; end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL merge_inservice: got dispatch expected none"); end
    pi_wr(32'd4);
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (intrqst !== 2'b00) seen = 1'b1; end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL merge_eoi_noedge: got dispatch expected none"); end
    pulse_src(8'h02);
    wait_rqst(2'b01, 3, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL merge_src1: got %b expected 01", intrqst); end
    rdy_man = 2'b00;
    @(negedge clk);
    rdy_man = 2'b01;
    pi_wr(32'd9);
`ifndef INTCTRL_IPI_EN
    pi_wr(32'h8000_0001);
`endif
    pulse_src(8'h02);
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (intrqst !== 2'b00) seen = 1'b1; end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL merge_out_of_range: got dispatch expected none"); end
    pi_rd(d);
    n_vec++;
    if (d !== 32'd4) begin n_err++; $display("FAIL merge_rd4: got %h expected 4", d); end
    pi_rd(d);
    n_vec++;
    if (d !== 32'd1) begin n_err++; $display("FAIL merge_rd1: got %h expected 1", d); end
    pi_rd(d);
    n_vec++;
    if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL merge_rd_empty: got %h expected ffffffff", d); end
    @(negedge clk); op = 2'd1; wdata = 32'd1; src = 8'h02;
    @(negedge clk); op = 2'd0; src = '0;
    wait_rqst(2'b01, 3, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL merge_eoi_with_edge: got %b expected 01", intrqst); end
    rdy_man = 2'b00;
    @(negedge clk);
    pi_rd(d);
    n_vec++;
    if (d !== 32'd1) begin n_err++; $display("FAIL merge_eoi_claim: got %h expected 1", d); end
  endtask

  task automatic test_reset_in_sent();
    logic [31:0] d;
    bit ok;
    do_reset();
    rdy_man = 2'b01;
    pulse_src(8'h40);
    wait_rqst(2'b01, 3, ok);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (intrqst !== 2'b00) begin n_err++; $display("FAIL rst_sent_drop: got %b expected 00", intrqst); end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if (intrqst !== 2'b00) begin n_err++; $display("FAIL rst_sent_lost: got %b expected 00", intrqst); end
    pi_rd(d);
    n_vec++;
    if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_sent_fifo: got %h expected ffffffff", d); end
  endtask

`ifdef INTCTRL_IPI_EN
  task automatic test_ipi();
    logic [31:0] d;
    bit ok;
    do_reset();
    rdy_man = 2'b10;
    pi_wr(32'h8000_0001);
    wait_rqst(2'b10, 3, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL ipi_rqst: got %b expected 10", intrqst); end
    rdy_man = 2'b00;
    @(negedge clk);
    pi_rd(d);
    n_vec++;
    if (d !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL ipi_claim: got %h expected fffffffe", d); end
  endtask
`endif

  // Model: with all of a burst pending before dispatch starts, claims come out in
  // circular id order starting from one past the previously dispatched source.
  task automatic test_random();
    logic [31:0] d;
    logic [7:0]  mask;
    int unsigned ptr;
    int unsigned exp[$];
    int unsigned ids[$];
    int unsigned k;
    do_reset();
    auto_en = 1'b1;
    ptr = 0;
    for (int r = 0; r < 12; r++) begin
      mask = 8'($urandom_range(255, 1));
      exp.delete();
      for (int unsigned j = 0; j < SRCCOUNT; j++) begin
        if (mask[(ptr + j) % SRCCOUNT]) exp.push_back((ptr + j) % SRCCOUNT);
      end
      ptr = (exp[exp.size() - 1] + 1) % SRCCOUNT;
      pulse_src(mask);
      while (exp.size() > 0) begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          n_vec++;
          if ($countones(intrqst) > 1) begin n_err++; $display("FAIL rnd_onehot: got %b expected at most one bit", intrqst); end
        end
        n_vec++;
        if (intrqst !== 2'b00) begin n_err++; $display("FAIL rnd_stall: got %b expected 00", intrqst); end
        k = (exp.size() < PUCOUNT) ? exp.size() : PUCOUNT;
        ids.delete();
        for (int unsigned j = 0; j < k; j++) begin
          pi_rd(d);
          n_vec++;
          if (d !== exp[0]) begin n_err++; $display("FAIL rnd_claim: round %0d got %h expected %h", r, d, exp[0]); end
          ids.push_back(exp.pop_front());
        end
        foreach (ids[j]) pi_wr(ids[j]);
      end
      repeat (4) @(negedge clk);
      pi_rd(d);
      n_vec++;
      if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rnd_empty: round %0d got %h expected ffffffff", r, d); end
    end
    auto_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_sources();
    test_timeout();
    test_merge();
    test_reset_in_sent();
`ifdef INTCTRL_IPI_EN
    test_ipi();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/intctrl.md
Name: intctrl

Overview:
- Interrupt controller sitting directly upstream of the multi-PU cluster.
- Collects SRCCOUNT edge-triggered interrupt sources and dispatches each one to a PU that is ready, via that PU's intrqst/intrdy pair.
- A PU claims the source id and signals end-of-interrupt through a single-register PI1 slave port. This port hangs off the same memory bus the PUs master.

Parameters:
- ARCHBITSZ, 32, data width of the PI1 port (16/32/64).
- PUCOUNT, 2, number of PUs served; non-null.
- SRCCOUNT, 8, number of interrupt sources; 1..(2**(ARCHBITSZ-1))-1.
- ACKTIMEOUT, 1024, cycles to wait for a PU to take a request before withdrawing it; 0 means never.

Ports:
- clk_i, in, 1, sole clock.
- rst_i, in, 1, reset; asynchronous, active-low.
- src_i, in, SRCCOUNT, interrupt sources; a rising edge makes the source pending.
- intrqst_o, out, PUCOUNT, per-PU interrupt request.
- intrdy_i, in, PUCOUNT, per-PU ready-to-take-interrupt.
- pi1_op_i, in, 2, PI1 op: 0 NOOP, 1 WR, 2 RD, 3 RW.
- pi1_addr_i, in, ARCHBITSZ-clog2(ARCHBITSZ/8), word address; ignored (single register).
- pi1_data_i, in, ARCHBITSZ, write data.
- pi1_data_o, out, ARCHBITSZ, read data.
- pi1_sel_i, in, ARCHBITSZ/8, byte select; ignored, full-word access only.
- pi1_rdy_o, out, 1, slave ready.

Behaviour:
- Reset (rst_i low, async): intrqst_o=0, pi1_data_o=0, pi1_rdy_o=1.
  - Cleared: pending, inservice, claim FIFO, RR pointers, timeout counter, src_i edge-detect register.
  - FSM goes to IDLE.
- Edge detect: src_q registered each cycle; pending[s] set when src_i[s]&~src_q[s].
  - An edge on a source already pending or inservice is merged: no second dispatch.
- Source arbitration: round-robin over pending[s]&~inservice[s], starting after the last dispatched source.
- PU arbitration: round-robin over intrdy_i[p], starting after the last targeted PU.
- FSM:
  - IDLE: if eligible source, ready PU and FIFO not full -> latch (s,p); intrqst_o[p]=1 next cycle; go to SENT.
  - SENT, intrdy_i[p]==0 (PU took it): deassert intrqst_o[p]; clear pending[s]; set inservice[s]; push s into claim FIFO; go to IDLE. One dispatch per 2 cycles at most.
  - SENT, timeout: if ACKTIMEOUT!=0 and the counter reaches ACKTIMEOUT-1 with intrdy_i[p] still 1, deassert intrqst_o[p]; source stays pending; advance PU pointer; go to IDLE.
- Only one intrqst_o bit is high at any time.
- Claim FIFO: depth PUCOUNT; dispatch stalls while full.
- PI1 slave:
  - pi1_rdy_o is constant 1; ops are sampled every cycle.
  - Read data is registered: valid the cycle after the op.
  - RD: pops FIFO and returns the source id; empty returns all ones.
  - WR: data = source id < SRCCOUNT clears inservice[id]. Out-of-range ids and ids not in service are ignored.
  - RW: pop/return, then clear inservice of the written id, in the same cycle.
  - NOOP: pi1_data_o holds its value.
- Simultaneous FIFO push and pop in one cycle: both are performed; a pop of an empty FIFO does not see the same-cycle push.
- A WR clearing inservice[s] in the same cycle that a new edge on s arrives: pending is set, then s becomes eligible on the next cycle.
- Reset in SENT: intrqst_o drops asynchronously; all state is lost.

Optional Feature:
- INTCTRL_IPI_EN defined:
  - WR with data[ARCHBITSZ-1]=1 is an inter-processor interrupt to PU data[clog2(PUCOUNT)-1:0].
  - Sets a per-PU ipipending bit, which has priority over sources for that PU when intrdy_i is high.
  - It is dispatched by the same FSM and pushes id all-ones-minus-1 (0x...FFFE) into the FIFO.
  - It never touches inservice; an out-of-range PU index is ignored.
- Undefined: data[ARCHBITSZ-1] is treated as part of the source id, so the write is out of range and ignored. No ipipending logic is built.

Test Plan:
- Reset with src_i=0 -> intrqst_o=0, RD returns 0xFFFFFFFF, pi1_rdy_o=1.
- Rising edge on src_i[3]; intrdy_i=2'b01 -> intrqst_o=2'b01 within 2 cycles. Then drop intrdy_i[0] -> intrqst_o=0, RD returns 3, WR 3 clears inservice. A second edge on src 3 then redispatches.
- Edges on src 1 and 5 in the same cycle; both PUs ready -> src 1 goes to PU0, then src 5 goes to PU1. RD,RD returns 1,5; a third RD returns all ones.
- ACKTIMEOUT=16, intrdy_i[0] held at 1, src 2 edge -> intrqst_o[0] high for exactly 16 cycles, then low. Src 2 is retried to the next ready PU.
- Edge on src 4 while inservice[4] -> no dispatch; WR 4 without a new edge -> no dispatch. WR 9 with SRCCOUNT=8 -> state unchanged.
- With INTCTRL_IPI_EN: WR 0x80000001 -> intrqst_o[1] asserted; after the take, RD returns 0xFFFFFFFE.
